// File: rtl/idli_sqi_mem_m.sv
// -----------------------------------------------------------------------------
// idli_sqi_mem_m
//
// SQI SRAM responder. This is the memory end of a quad-SPI link in 23LC style.
// It decodes READ (0x03) and WRITE (0x02), each followed by a 16-bit address.
// A READ also takes one dummy byte before its data. Data is sequential.
// Storage is an internal byte array of 2^ADDR_W bytes. Address bits above
// ADDR_W alias.
//
// SCK is oversampled on the system clock. It must hold each level for at
// least one i_mem_gck cycle.
//
// Parameters:
//   ADDR_W          log2 of the array depth in bytes (default 8)
//
// Ports:
//   i_mem_gck       system clock, all logic on posedge
//   i_mem_rst       synchronous active-high reset
//   i_mem_sqi_sck   SQI clock from initiator (synchronous to i_mem_gck)
//   i_mem_sqi_cs    chip select, active-low
//   i_mem_sqi_data  nibble from initiator, sampled on detected SCK rise
//   o_mem_sqi_data  nibble to initiator, updated on detected SCK fall
//   o_mem_sqi_oe    high while the responder drives o_mem_sqi_data
//
// Optional feature: define IDLI_SQI_MEM_MODE_REG_EN to add the mode
// register. It adds WRMR 0x01 and RDMR 0x05, and byte/page/sequential
// addressing. Without it, 0x01 and 0x05 are unknown opcodes.
// -----------------------------------------------------------------------------
module idli_sqi_mem_m #(
  parameter int ADDR_W = 8
) (
  input  logic       i_mem_gck,
  input  logic       i_mem_rst,
  input  logic       i_mem_sqi_sck,
  input  logic       i_mem_sqi_cs,
  input  logic [3:0] i_mem_sqi_data,
  output logic [3:0] o_mem_sqi_data,
  output logic       o_mem_sqi_oe
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RD,
    ST_WR,
    ST_IGNORE,
    ST_MODE_WR,
    ST_MODE_RD
  } state_t;

  state_t              state_q;
  logic                sck_q;
  logic [1:0]          cnt_q;       // nibble counter within the current phase
  logic [3:0]          op_hi_q;     // first opcode nibble
  logic                is_rd_q;     // ADDR phase belongs to a READ
  logic [ADDR_W-1:0]   addr_q;
  logic [3:0]          wr_hi_q;     // high nibble of the byte being written
  logic                lo_next_q;   // next fall drives the low nibble
  logic                byte_done_q; // one full byte already transferred
  logic [3:0]          data_q;
  logic                oe_q;
  logic [7:0]          rd_q;        // read shift register, loaded from array

  logic                rise;
  logic                fall;
  logic                active;
  logic                byte_mode;
  logic [ADDR_W-1:0]   addr_inc;
  logic                mem_we;
  logic                mem_re_first;
  logic                mem_re_next;
  logic [ADDR_W-1:0]   mem_addr;
  logic [7:0]          mem_wdata;

  logic [7:0]          mem_q [0:DEPTH-1];

`ifdef IDLI_SQI_MEM_MODE_REG_EN
  logic [7:0]          mode_q;
  logic [3:0]          mode_hi_q;
`endif

  assign rise   = i_mem_sqi_sck & ~sck_q;
  assign fall   = ~i_mem_sqi_sck & sck_q;
  // A deasserted chip select or a reset suppresses all sampling and writes.
  assign active = ~i_mem_rst & ~i_mem_sqi_cs;

`ifdef IDLI_SQI_MEM_MODE_REG_EN
  assign byte_mode = (mode_q[7:6] == 2'b00);
`else
  assign byte_mode = 1'b0;
`endif

  // Next sequential address. In page mode only the low five bits advance.
  always_comb begin
    addr_inc = addr_q + ADDR_W'(1);
`ifdef IDLI_SQI_MEM_MODE_REG_EN
    if (mode_q[7:6] == 2'b10) begin
      addr_inc = {addr_q[ADDR_W-1:5], addr_q[4:0] + 5'd1};
    end
`endif
  end

  // Array access strobes, decoded from the same events the FSM reacts to.
  assign mem_we       = active & rise & (state_q == ST_WR) & (cnt_q == 2'd1);
  assign mem_re_first = active & rise & (state_q == ST_DUMMY) & (cnt_q == 2'd1);
  // The prefetch happens when the low nibble leaves, so the next byte is
  // ready before the following high-nibble fall.
  assign mem_re_next  = active & fall & (state_q == ST_RD) & lo_next_q;
  assign mem_addr     = mem_re_next ? addr_inc : addr_q;
  assign mem_wdata    = {wr_hi_q, i_mem_sqi_data};

  // Byte array with a registered read port. The array contents are not reset.
  always_ff @(posedge i_mem_gck) begin
    if (mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
    if (mem_re_first || mem_re_next) begin
      rd_q <= mem_q[mem_addr];
    end
  end

  always_ff @(posedge i_mem_gck) begin
    if (i_mem_rst) begin
      sck_q       <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      op_hi_q     <= 4'd0;
      is_rd_q     <= 1'b0;
      addr_q      <= '0;
      wr_hi_q     <= 4'd0;
      lo_next_q   <= 1'b0;
      byte_done_q <= 1'b0;
      data_q      <= 4'd0;
      oe_q        <= 1'b0;
`ifdef IDLI_SQI_MEM_MODE_REG_EN
      mode_q      <= 8'h40;
      mode_hi_q   <= 4'd0;
`endif
    end else begin
      sck_q <= i_mem_sqi_sck;
      if (i_mem_sqi_cs) begin
        // Deselect aborts whatever is in flight. Partial bytes are dropped.
        state_q <= ST_IDLE;
        oe_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_CMD;
            cnt_q   <= 2'd0;
          end

          ST_CMD: begin
            if (rise) begin
              if (cnt_q == 2'd0) begin
                op_hi_q <= i_mem_sqi_data;
                cnt_q   <= 2'd1;
              end else begin
                cnt_q     <= 2'd0;
                lo_next_q <= 1'b0;
                case ({op_hi_q, i_mem_sqi_data})
                  8'h03: begin
                    is_rd_q <= 1'b1;
                    state_q <= ST_ADDR;
                  end
                  8'h02: begin
                    is_rd_q <= 1'b0;
                    state_q <= ST_ADDR;
                  end
`ifdef IDLI_SQI_MEM_MODE_REG_EN
                  8'h01:   state_q <= ST_MODE_WR;
                  8'h05:   state_q <= ST_MODE_RD;
`endif
                  default: state_q <= ST_IGNORE;
                endcase
              end
            end
          end

          ST_ADDR: begin
            if (rise) begin
              // Shift in MS nibble first. Bits above ADDR_W fall off the top.
              addr_q <= ADDR_W'({addr_q, i_mem_sqi_data});
              cnt_q  <= cnt_q + 2'd1;
              if (cnt_q == 2'd3) begin
                byte_done_q <= 1'b0;
                state_q     <= is_rd_q ? ST_DUMMY : ST_WR;
              end
            end
          end

          ST_DUMMY: begin
            if (rise) begin
              if (cnt_q == 2'd0) begin
                cnt_q <= 2'd1;
              end else begin
                cnt_q     <= 2'd0;
                lo_next_q <= 1'b0;
                state_q   <= ST_RD;
              end
            end
          end

          ST_RD: begin
            if (fall) begin
              if (!lo_next_q && byte_mode && byte_done_q) begin
                state_q <= ST_IGNORE;
                oe_q    <= 1'b0;
              end else if (!lo_next_q) begin
                data_q    <= rd_q[7:4];
                oe_q      <= 1'b1;
                lo_next_q <= 1'b1;
              end else begin
                data_q      <= rd_q[3:0];
                oe_q        <= 1'b1;
                lo_next_q   <= 1'b0;
                addr_q      <= addr_inc;
                byte_done_q <= 1'b1;
              end
            end
          end

          ST_WR: begin
            if (rise) begin
              if (cnt_q == 2'd0) begin
                wr_hi_q <= i_mem_sqi_data;
                cnt_q   <= 2'd1;
              end else begin
                cnt_q  <= 2'd0;
                addr_q <= addr_inc;
                if (byte_mode) begin
                  state_q <= ST_IGNORE;
                end
              end
            end
          end

`ifdef IDLI_SQI_MEM_MODE_REG_EN
          ST_MODE_WR: begin
            if (rise) begin
              if (cnt_q == 2'd0) begin
                mode_hi_q <= i_mem_sqi_data;
                cnt_q     <= 2'd1;
              end else begin
                cnt_q   <= 2'd0;
                mode_q  <= {mode_hi_q, i_mem_sqi_data};
                state_q <= ST_IGNORE;
              end
            end
          end

          ST_MODE_RD: begin
            if (fall) begin
              data_q    <= lo_next_q ? mode_q[3:0] : mode_q[7:4];
              oe_q      <= 1'b1;
              lo_next_q <= ~lo_next_q;
            end
          end
`endif

          ST_IGNORE: begin
            oe_q <= 1'b0;
          end

          default: begin
            state_q <= ST_IDLE;
            oe_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_mem_sqi_data = data_q;
  assign o_mem_sqi_oe   = oe_q;

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// -----------------------------------------------------------------------------
// tb_idli_sqi_mem_m
//
// Scoreboard bench for idli_sqi_mem_m. Each task that drives an SCK rise
// first queues the expected {oe, nibble} for that rise. A monitor process
// pops one entry per SCK rise while cs is low and compares it.
//
// The reference memory is a plain byte array. It is indexed modulo the
// array depth.
// -----------------------------------------------------------------------------
module tb_idli_sqi_mem_m;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic       clk;
  logic       rst;
  logic       sck;
  logic       cs;
  logic [3:0] din;
  logic [3:0] dout;
  logic       oe;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       oe;
    logic [3:0] d;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] ref_mem [0:DEPTH-1];
  logic [7:0] buf_b   [0:7];
  logic [7:0] ref_mode = 8'h40;

  idli_sqi_mem_m #(.ADDR_W(ADDR_W)) dut (
    .i_mem_gck      (clk),
    .i_mem_rst      (rst),
    .i_mem_sqi_sck  (sck),
    .i_mem_sqi_cs   (cs),
    .i_mem_sqi_data (din),
    .o_mem_sqi_data (dout),
    .o_mem_sqi_oe   (oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One check per SCK rise seen by the responder.
  always @(posedge sck) begin
    if (!cs && !rst) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got a rise, expected no rise");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("oe_at_rise", {7'd0, oe}, {7'd0, e.oe});
        if (e.oe) chk("rd_nibble", {4'd0, dout}, {4'd0, e.d});
      end
    end
  end

  // Reference-model address step. Sequential mode wraps over the whole
  // array. Page mode stays inside the current 32-byte page.
  function automatic int next_addr(input int a);
    if (ref_mode[7:6] == 2'b10) return (a & ~31) | ((a + 1) & 31);
    return (a + 1) % DEPTH;
  endfunction

  task automatic nib(input logic [3:0] n);
    @(negedge clk);
    sck = 1'b0;
    din = n;
    repeat (2) @(negedge clk);
    sck = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic nib_exp(input logic [3:0] n, input logic e_oe, input logic [3:0] e_d);
    exp_q.push_back('{oe: e_oe, d: e_d});
    nib(n);
  endtask

  task automatic send_byte(input logic [7:0] b);
    nib_exp(b[7:4], 1'b0, 4'd0);
    nib_exp(b[3:0], 1'b0, 4'd0);
  endtask

  task automatic start_txn();
    @(negedge clk);
    cs = 1'b0;
    @(negedge clk);
  endtask

  task automatic end_txn();
    @(negedge clk);
    sck = 1'b0;
    repeat (2) @(negedge clk);
    cs = 1'b1;
    repeat (2) @(negedge clk);
    chk("oe_after_cs", {7'd0, oe}, 8'h00);
  endtask

  task automatic send_addr(input logic [15:0] a);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
  endtask

  // Writes n bytes from buf_b starting at a.
  task automatic wr_txn(input logic [15:0] a, input int n);
    int idx;
    idx = int'(a) % DEPTH;
    start_txn();
    send_byte(8'h02);
    send_addr(a);
    for (int i = 0; i < n; i++) begin
      send_byte(buf_b[i]);
      if (!(ref_mode[7:6] == 2'b00 && i > 0)) begin
        ref_mem[idx] = buf_b[i];
        idx = next_addr(idx);
      end
    end
    end_txn();
  endtask

  task automatic rd_txn(input logic [15:0] a, input int n);
    int idx;
    logic [7:0] b;
    idx = int'(a) % DEPTH;
    start_txn();
    send_byte(8'h03);
    send_addr(a);
    send_byte(8'($urandom));
    for (int i = 0; i < n; i++) begin
      if (ref_mode[7:6] == 2'b00 && i > 0) begin
        nib_exp(4'($urandom), 1'b0, 4'd0);
        nib_exp(4'($urandom), 1'b0, 4'd0);
      end else begin
        b = ref_mem[idx];
        nib_exp(4'($urandom), 1'b1, b[7:4]);
        nib_exp(4'($urandom), 1'b1, b[3:0]);
        idx = next_addr(idx);
      end
    end
    end_txn();
  endtask

`ifdef IDLI_SQI_MEM_MODE_REG_EN
  task automatic wrmr(input logic [7:0] m);
    start_txn();
    send_byte(8'h01);
    send_byte(m);
    ref_mode = m;
    end_txn();
    $display("txn WRMR mode=%h", m);
  endtask

  task automatic rdmr();
    start_txn();
    send_byte(8'h05);
    for (int i = 0; i < 2; i++) begin
      nib_exp(4'($urandom), 1'b1, ref_mode[7:4]);
      nib_exp(4'($urandom), 1'b1, ref_mode[3:0]);
    end
    end_txn();
    $display("txn RDMR expected=%h", ref_mode);
  endtask
`endif

  initial begin
    logic [15:0] ra;
    int          rn;
    logic [7:0]  saved;

    rst = 1'b1;
    cs  = 1'b1;
    sck = 1'b0;
    din = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset_oe", {7'd0, oe}, 8'h00);
    chk("reset_data", {4'd0, dout}, 8'h00);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Fill the whole array so every later read has a known answer.
    start_txn();
    send_byte(8'h02);
    send_addr(16'h0000);
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = 8'($urandom);
      send_byte(ref_mem[i]);
    end
    end_txn();
    $display("txn FILL %0d bytes", DEPTH);

    // Write then read.
    buf_b[0] = 8'hA5;
    buf_b[1] = 8'h3C;
    wr_txn(16'h0010, 2);
    $display("txn WRITE addr=0010 data=A5 3C");
    rd_txn(16'h0010, 2);
    $display("txn READ addr=0010 n=2");

    // Address wrap.
    buf_b[0] = 8'h11;
    buf_b[1] = 8'h22;
    wr_txn(16'h00FF, 2);
    $display("txn WRITE addr=00FF data=11 22");
    rd_txn(16'h00FF, 2);
    $display("txn READ addr=00FF n=2");
    rd_txn(16'h0000, 1);
    $display("txn READ addr=0000 n=1");

    // Partial write abort. The cs-high cycle also carries an SCK rise.
    start_txn();
    send_byte(8'h02);
    send_addr(16'h0020);
    nib_exp(4'h7, 1'b0, 4'd0);
    @(negedge clk);
    sck = 1'b0;
    din = 4'h9;
    repeat (2) @(negedge clk);
    cs  = 1'b1;
    sck = 1'b1;
    repeat (2) @(negedge clk);
    sck = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_oe", {7'd0, oe}, 8'h00);
    $display("txn WRITE-ABORT addr=0020");
    rd_txn(16'h0020, 1);
    $display("txn READ addr=0020 n=1");

    // Unknown opcode.
    start_txn();
    send_byte(8'h9F);
    for (int i = 0; i < 8; i++) nib_exp(4'($urandom), 1'b0, 4'd0);
    end_txn();
    $display("txn UNKNOWN op=9F");
    rd_txn(16'h0010, 2);
    $display("txn READ addr=0010 n=2");

    // Reset after the first data nibble of a read.
    saved = ref_mem[8'h33];
    start_txn();
    send_byte(8'h03);
    send_addr(16'h0033);
    send_byte(8'h00);
    nib_exp(4'h0, 1'b1, saved[7:4]);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_read_oe", {7'd0, oe}, 8'h00);
    rst = 1'b0;
    cs  = 1'b1;
    sck = 1'b0;
    repeat (2) @(negedge clk);
    $display("txn READ-RESET addr=0033");
    rd_txn(16'h0033, 1);
    $display("txn READ addr=0033 n=1");

    // Randomized traffic. Upper address bits exercise aliasing.
    for (int t = 0; t < 16; t++) begin
      ra = 16'($urandom);
      rn = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < rn; i++) buf_b[i] = 8'($urandom);
        wr_txn(ra, rn);
        $display("txn %0d: WRITE addr=%h n=%0d", t, ra, rn);
      end else begin
        rd_txn(ra, rn);
        $display("txn %0d: READ addr=%h n=%0d", t, ra, rn);
      end
    end

`ifdef IDLI_SQI_MEM_MODE_REG_EN
    rdmr();
    wrmr(8'h00);
    rd_txn(16'h0010, 2);
    $display("txn READ byte-mode addr=0010");
    wrmr(8'h80);
    rd_txn(16'h001F, 2);
    $display("txn READ page-mode addr=001F");
    rdmr();
    wrmr(8'h40);
`endif

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
